// File: rtl/mips_control_unit_pkg.sv
// Shared types for the multi-cycle MIPS control unit: ALU operation codes,
// opcode/funct constants, FSM state encoding and srcB select values.
package ALU_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } ALU_ctrl_e;

endpackage

package MIPS_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_SIGNIMM = 2'd2;
    localparam logic [1:0] SRCB_ZEROIMM = 2'd3;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ORIEX    = 4'd11,
        S_IMMWB    = 4'd12,
        S_TRAP     = 4'd13
    } mips_cu_state_e;

    function automatic logic is_supported_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI};
    endfunction

endpackage

// File: rtl/mips_control_unit_alu_decoder.sv
// R-type funct field to ALU operation decoder; unknown funct values fall
// back to ADD so a bad encoding never produces an undefined ALU op.
module mips_alu_decoder
    import ALU_pkg::*;
    import MIPS_pkg::*;
#(
    parameter int FUNCT_WIDTH = 6
) (
    input  logic [FUNCT_WIDTH-1:0] i_funct,
    output ALU_ctrl_e              o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_funct)
            FUNCT_ADD: o_alu_ctrl = ALU_ADD;
            FUNCT_SUB: o_alu_ctrl = ALU_SUB;
            FUNCT_AND: o_alu_ctrl = ALU_AND;
            FUNCT_OR:  o_alu_ctrl = ALU_OR;
            FUNCT_SLT: o_alu_ctrl = ALU_SLT;
            default:   o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Moore FSM controller for the multi-cycle MIPS datapath.
// Optional macro MIPS_CU_ILLEGAL_TRAP_EN: unsupported opcodes lock in S_TRAP.
module mips_control_unit
    import ALU_pkg::*;
    import MIPS_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic                    alu_zero,
    output logic                    en_pc,
    output logic                    en_instr_reg,
    output logic                    mem_we,
    output logic                    addr_mux_sel,
    output logic                    regdst_mux_sel,
    output logic                    writedata_mux_sel,
    output logic                    rf_we,
    output logic                    srcA_mux_sel,
    output logic [1:0]              srcB_mux_sel,
    output logic                    alurslt_mux_sel,
    output ALU_ctrl_e               alu_ctrl,
    output logic                    instr_done,
    output logic                    illegal_instr
);

    mips_cu_state_e r_state;
    mips_cu_state_e w_next_state;
    ALU_ctrl_e      w_funct_alu_ctrl;
    logic           w_pc_write;
    logic           w_branch;

    mips_alu_decoder #(
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_alu_decoder (
        .i_funct    (funct),
        .o_alu_ctrl (w_funct_alu_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode is held in the instruction register for the whole instruction,
    // so MEMADR can still tell lw from sw.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET:    w_next_state = S_FETCH;
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_ORI:       w_next_state = S_ORIEX;
`ifdef MIPS_CU_ILLEGAL_TRAP_EN
                    default:      w_next_state = S_TRAP;
`else
                    default:      w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECUTE:  w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_ADDIEX:   w_next_state = S_IMMWB;
            S_ORIEX:    w_next_state = S_IMMWB;
            S_IMMWB:    w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_RESET;
        endcase
    end

    always_comb begin
        en_instr_reg      = 1'b0;
        mem_we            = 1'b0;
        addr_mux_sel      = 1'b0;
        regdst_mux_sel    = 1'b0;
        writedata_mux_sel = 1'b0;
        rf_we             = 1'b0;
        srcA_mux_sel      = 1'b0;
        srcB_mux_sel      = SRCB_REG;
        alurslt_mux_sel   = 1'b0;
        alu_ctrl          = ALU_ADD;
        instr_done        = 1'b0;
        w_pc_write        = 1'b0;
        w_branch          = 1'b0;
        case (r_state)
            S_FETCH: begin
                en_instr_reg = 1'b1;
                srcB_mux_sel = SRCB_FOUR;
                w_pc_write   = 1'b1;
            end
            S_DECODE: begin
                srcB_mux_sel = SRCB_SIGNIMM;
`ifndef MIPS_CU_ILLEGAL_TRAP_EN
                instr_done   = ~is_supported_op(opcode);
`endif
            end
            S_MEMADR: begin
                srcA_mux_sel = 1'b1;
                srcB_mux_sel = SRCB_SIGNIMM;
            end
            S_MEMREAD: begin
                addr_mux_sel = 1'b1;
            end
            S_MEMWB: begin
                writedata_mux_sel = 1'b1;
                rf_we             = 1'b1;
                instr_done        = 1'b1;
            end
            S_MEMWRITE: begin
                addr_mux_sel = 1'b1;
                mem_we       = 1'b1;
                instr_done   = 1'b1;
            end
            S_EXECUTE: begin
                srcA_mux_sel = 1'b1;
                alu_ctrl     = w_funct_alu_ctrl;
            end
            S_ALUWB: begin
                regdst_mux_sel = 1'b1;
                rf_we          = 1'b1;
                instr_done     = 1'b1;
            end
            S_BRANCH: begin
                srcA_mux_sel    = 1'b1;
                alu_ctrl        = ALU_SUB;
                alurslt_mux_sel = 1'b1;
                w_branch        = 1'b1;
                instr_done      = 1'b1;
            end
            S_ADDIEX: begin
                srcA_mux_sel = 1'b1;
                srcB_mux_sel = SRCB_SIGNIMM;
            end
            S_ORIEX: begin
                srcA_mux_sel = 1'b1;
                srcB_mux_sel = SRCB_ZEROIMM;
                alu_ctrl     = ALU_OR;
            end
            S_IMMWB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign en_pc = w_pc_write | (w_branch & alu_zero);

    // The trap state is never left without reset, so decoding it is sticky.
`ifdef MIPS_CU_ILLEGAL_TRAP_EN
    assign illegal_instr = (r_state == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed self-checking bench for mips_control_unit; every output is packed
// into one vector per cycle and compared against hand-computed expectations.
module tb_mips_control_unit;
    import ALU_pkg::*;

    localparam logic [5:0] TB_OP_RTYPE = 6'b000000;
    localparam logic [5:0] TB_OP_LW    = 6'b100011;
    localparam logic [5:0] TB_OP_SW    = 6'b101011;
    localparam logic [5:0] TB_OP_BEQ   = 6'b000100;
    localparam logic [5:0] TB_OP_ADDI  = 6'b001000;
    localparam logic [5:0] TB_OP_ORI   = 6'b001101;
    localparam logic [5:0] TB_OP_BAD   = 6'b111111;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        en_pc;
    logic        en_instr_reg;
    logic        mem_we;
    logic        addr_mux_sel;
    logic        regdst_mux_sel;
    logic        writedata_mux_sel;
    logic        rf_we;
    logic        srcA_mux_sel;
    logic [1:0]  srcB_mux_sel;
    logic        alurslt_mux_sel;
    ALU_ctrl_e   alu_ctrl;
    logic        instr_done;
    logic        illegal_instr;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] E_RESET, E_FETCH, E_DECODE, E_DECODE_NOP, E_MEMADR, E_MEMREAD;
    logic [15:0] E_MEMWB, E_MEMWRITE, E_ALUWB, E_BR_T, E_BR_NT;
    logic [15:0] E_ADDIEX, E_ORIEX, E_IMMWB, E_TRAP;

    mips_control_unit #(
        .OPCODE_WIDTH (6),
        .FUNCT_WIDTH  (6)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .opcode            (opcode),
        .funct             (funct),
        .alu_zero          (alu_zero),
        .en_pc             (en_pc),
        .en_instr_reg      (en_instr_reg),
        .mem_we            (mem_we),
        .addr_mux_sel      (addr_mux_sel),
        .regdst_mux_sel    (regdst_mux_sel),
        .writedata_mux_sel (writedata_mux_sel),
        .rf_we             (rf_we),
        .srcA_mux_sel      (srcA_mux_sel),
        .srcB_mux_sel      (srcB_mux_sel),
        .alurslt_mux_sel   (alurslt_mux_sel),
        .alu_ctrl          (alu_ctrl),
        .instr_done        (instr_done),
        .illegal_instr     (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: en_pc, en_ir, mem_we, addr, regdst, wdsel, rf_we, srcA,
    // srcB[1:0], alurslt, alu_ctrl[2:0], instr_done, illegal_instr.
    function automatic logic [15:0] expv(input logic pc, input logic ir, input logic we,
                                         input logic addr, input logic rd, input logic wd,
                                         input logic rf, input logic sa, input logic [1:0] sb,
                                         input logic ar, input logic [2:0] alu, input logic done);
        return {pc, ir, we, addr, rd, wd, rf, sa, sb, ar, alu, done, 1'b0};
    endfunction

    function automatic logic [15:0] observed();
        return {en_pc, en_instr_reg, mem_we, addr_mux_sel, regdst_mux_sel, writedata_mux_sel,
                rf_we, srcA_mux_sel, srcB_mux_sel, alurslt_mux_sel, alu_ctrl, instr_done,
                illegal_instr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        alu_zero = 1'b0;
        #2;
        compared++;
        if (observed() !== E_RESET) begin
            mismatched++;
            $display("[TB] FAIL reset_async: got %h expected %h", observed(), E_RESET);
        end
        tick();
        tick();
        compared++;
        if (observed() !== E_RESET) begin
            mismatched++;
            $display("[TB] FAIL reset_held: got %h expected %h", observed(), E_RESET);
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL reset_release_fetch: got %h expected %h", observed(), E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [15:0] seq [5];
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
        opcode   = TB_OP_LW;
        alu_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (observed() !== seq[i]) begin
                mismatched++;
                $display("[TB] FAIL lw cycle %0d: got %h expected %h", i, observed(), seq[i]);
            end
            tick();
        end
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL lw_next_fetch: got %h expected %h", observed(), E_FETCH);
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_sw();
        logic [15:0] seq [4];
        seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE};
        opcode = TB_OP_SW;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (observed() !== seq[i]) begin
                mismatched++;
                $display("[TB] FAIL sw cycle %0d: got %h expected %h", i, observed(), seq[i]);
            end
            tick();
        end
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL sw_next_fetch: got %h expected %h", observed(), E_FETCH);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn  [6];
        logic [2:0]  alu [6];
        logic [15:0] seq [4];
        int          dones;
        fn  = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        alu = '{ALU_SUB, ALU_ADD, ALU_AND, ALU_OR, ALU_SLT, ALU_ADD};
        opcode = TB_OP_RTYPE;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            seq   = '{E_FETCH, E_DECODE, expv(0,0,0,0,0,0,0,1,2'd0,0,alu[k],0), E_ALUWB};
            dones = 0;
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (observed() !== seq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL rtype funct %b cycle %0d: got %h expected %h",
                             fn[k], i, observed(), seq[i]);
                end
                if (instr_done === 1'b1) dones++;
                tick();
            end
            compared++;
            if (dones != 1) begin
                mismatched++;
                $display("[TB] FAIL rtype_done_count funct %b: got %0d expected 1", fn[k], dones);
            end
        end
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL rtype_next_fetch: got %h expected %h", observed(), E_FETCH);
        end
        funct = 6'b000000;
    endtask

    task automatic test_beq();
        logic [15:0] seq [3];
        opcode = TB_OP_BEQ;
        for (int k = 0; k < 2; k++) begin
            alu_zero = (k == 0);
            seq = '{E_FETCH, E_DECODE, (k == 0) ? E_BR_T : E_BR_NT};
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (observed() !== seq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL beq zero=%0d cycle %0d: got %h expected %h",
                             alu_zero, i, observed(), seq[i]);
                end
                tick();
            end
            compared++;
            if (observed() !== E_FETCH) begin
                mismatched++;
                $display("[TB] FAIL beq_next_fetch zero=%0d: got %h expected %h",
                         alu_zero, observed(), E_FETCH);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_addi();
        logic [15:0] seq [4];
        seq = '{E_FETCH, E_DECODE, E_ADDIEX, E_IMMWB};
        opcode = TB_OP_ADDI;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (observed() !== seq[i]) begin
                mismatched++;
                $display("[TB] FAIL addi cycle %0d: got %h expected %h", i, observed(), seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_ori();
        logic [15:0] seq [4];
        seq = '{E_FETCH, E_DECODE, E_ORIEX, E_IMMWB};
        opcode = TB_OP_ORI;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (observed() !== seq[i]) begin
                mismatched++;
                $display("[TB] FAIL ori cycle %0d: got %h expected %h", i, observed(), seq[i]);
            end
            tick();
        end
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL ori_next_fetch: got %h expected %h", observed(), E_FETCH);
        end
    endtask

    task automatic test_reset_mid();
        opcode = TB_OP_LW;
        tick();
        tick();
        tick();
        compared++;
        if (observed() !== E_MEMREAD) begin
            mismatched++;
            $display("[TB] FAIL midreset_in_memread: got %h expected %h", observed(), E_MEMREAD);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (observed() !== E_RESET) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got %h expected %h", observed(), E_RESET);
        end
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL midreset_release_fetch: got %h expected %h", observed(), E_FETCH);
        end
    endtask

    task automatic test_illegal();
        opcode = TB_OP_BAD;
`ifdef MIPS_CU_ILLEGAL_TRAP_EN
        begin
            logic [15:0] seq [6];
            seq = '{E_FETCH, E_DECODE, E_TRAP, E_TRAP, E_TRAP, E_TRAP};
            for (int i = 0; i < 6; i++) begin
                compared++;
                if (observed() !== seq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL trap cycle %0d: got %h expected %h", i, observed(), seq[i]);
                end
                if (i < 5) tick();
            end
            rst_n = 1'b0;
            #1;
            compared++;
            if (observed() !== E_RESET) begin
                mismatched++;
                $display("[TB] FAIL trap_reset_clears: got %h expected %h", observed(), E_RESET);
            end
            tick();
            rst_n  = 1'b1;
            opcode = TB_OP_RTYPE;
            tick();
        end
`else
        begin
            logic [15:0] seq [2];
            seq = '{E_FETCH, E_DECODE_NOP};
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (observed() !== seq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL illegal_nop cycle %0d: got %h expected %h",
                             i, observed(), seq[i]);
                end
                tick();
            end
        end
`endif
        compared++;
        if (observed() !== E_FETCH) begin
            mismatched++;
            $display("[TB] FAIL illegal_next_fetch: got %h expected %h", observed(), E_FETCH);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        E_RESET      = expv(0,0,0,0,0,0,0,0,2'd0,0,ALU_ADD,0);
        E_FETCH      = expv(1,1,0,0,0,0,0,0,2'd1,0,ALU_ADD,0);
        E_DECODE     = expv(0,0,0,0,0,0,0,0,2'd2,0,ALU_ADD,0);
        E_DECODE_NOP = expv(0,0,0,0,0,0,0,0,2'd2,0,ALU_ADD,1);
        E_MEMADR     = expv(0,0,0,0,0,0,0,1,2'd2,0,ALU_ADD,0);
        E_MEMREAD    = expv(0,0,0,1,0,0,0,0,2'd0,0,ALU_ADD,0);
        E_MEMWB      = expv(0,0,0,0,0,1,1,0,2'd0,0,ALU_ADD,1);
        E_MEMWRITE   = expv(0,0,1,1,0,0,0,0,2'd0,0,ALU_ADD,1);
        E_ALUWB      = expv(0,0,0,0,1,0,1,0,2'd0,0,ALU_ADD,1);
        E_BR_T       = expv(1,0,0,0,0,0,0,1,2'd0,1,ALU_SUB,1);
        E_BR_NT      = expv(0,0,0,0,0,0,0,1,2'd0,1,ALU_SUB,1);
        E_ADDIEX     = expv(0,0,0,0,0,0,0,1,2'd2,0,ALU_ADD,0);
        E_ORIEX      = expv(0,0,0,0,0,0,0,1,2'd3,0,ALU_OR,0);
        E_IMMWB      = expv(0,0,0,0,0,0,1,0,2'd0,0,ALU_ADD,1);
        E_TRAP       = E_RESET | 16'h0001;

        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi();
        test_ori();
        test_reset_mid();
        test_illegal();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Moore FSM controller for the multi-cycle, non-pipelined MIPS datapath.
- Receives opcode/funct from the instruction register and the ALU zero flag.
- Drives every datapath enable, mux select and ALU control, one state per datapath cycle.
- Sits beside the datapath in the MIPS top level; together they form the complete core.

Parameters:
OPCODE_WIDTH, 6, instruction opcode field width
FUNCT_WIDTH, 6, R-type funct field width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
opcode  input  OPCODE_WIDTH  instruction[31:26] from instruction register
funct  input  FUNCT_WIDTH  instruction[5:0]
alu_zero  input  1  high when combinational ALU result == 0
en_pc  output  1  PC register enable
en_instr_reg  output  1  instruction register enable
mem_we  output  1  memory write enable
addr_mux_sel  output  1  0=PC, 1=ALU_result
regdst_mux_sel  output  1  0=rt, 1=rd
writedata_mux_sel  output  1  0=ALU_result, 1=data register
rf_we  output  1  register file WE3
srcA_mux_sel  output  1  0=PC, 1=A
srcB_mux_sel  output  2  0=B, 1=constant 4, 2=sign-extended imm, 3=zero-extended imm
alurslt_mux_sel  output  1  next_pc source: 0=alu_out, 1=ALU_result
alu_ctrl  output  ALU_ctrl_e  ALU operation
instr_done  output  1  one-cycle pulse in final state of each instruction
illegal_instr  output  1  sticky unsupported-opcode flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Asynchronous active-low reset forces state S_RESET, including mid-instruction.
  - In S_RESET all enables/we/instr_done/illegal_instr are 0, all selects 0, alu_ctrl=ALU_ADD.
  - S_RESET always goes to S_FETCH on the next clock.
- Outputs: functions of state only, except en_pc = pc_write | (branch & alu_zero).
- Unlisted outputs are 0 in every state; alu_ctrl defaults to ALU_ADD.
- S_FETCH:
  - addr=0, en_instr_reg=1, srcA=0, srcB=1, ADD, alurslt=0, pc_write=1.
  - Next: S_DECODE.
- S_DECODE:
  - srcA=0, srcB=2, ADD; the branch target lands in ALU_result.
  - Next state by opcode:
    - lw/sw -> S_MEMADR
    - R-type (000000) -> S_EXECUTE
    - beq (000100) -> S_BRANCH
    - addi (001000) -> S_ADDIEX
    - ori (001101) -> S_ORIEX
    - other -> see Optional Feature.
- S_MEMADR: srcA=1, srcB=2, ADD. Next: lw (100011) -> S_MEMREAD; sw (101011) -> S_MEMWRITE.
- S_MEMREAD: addr=1. Next: S_MEMWB.
- S_MEMWB: regdst=0, writedata=1, rf_we=1, instr_done. Next: S_FETCH.
- S_MEMWRITE: addr=1, mem_we=1, instr_done. Next: S_FETCH.
- S_EXECUTE:
  - srcA=1, srcB=0, alu_ctrl decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Unknown funct -> ADD.
  - Next: S_ALUWB.
- S_ALUWB: regdst=1, writedata=0, rf_we=1, instr_done. Next: S_FETCH.
- S_BRANCH:
  - srcA=1, srcB=0, SUB, alurslt=1, branch=1, instr_done.
  - PC loads the target only when alu_zero=1.
  - Next: S_FETCH.
- S_ADDIEX: srcA=1, srcB=2, ADD. Next: S_IMMWB.
- S_ORIEX: srcA=1, srcB=3, OR. Next: S_IMMWB.
- S_IMMWB: regdst=0, writedata=0, rf_we=1, instr_done. Next: S_FETCH.
- Latency (cycles, FETCH through final state):
  - lw 5
  - sw 4
  - R-type 4
  - addi/ori 4
  - beq 3
- alu_zero is ignored outside S_BRANCH.

Optional Feature:
- Macro MIPS_CU_ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode in S_DECODE -> S_TRAP.
  - S_TRAP holds all enables 0 and stays until reset.
  - illegal_instr is set on entry and sticky until reset.
- Undefined:
  - Unsupported opcode -> S_FETCH with instr_done pulsed in S_DECODE (executes as NOP).
  - illegal_instr tied 0.

Decomposition:
- MIPS_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI)
  - funct constants
  - mips_cu_state_e enum
  - srcB select localparams
- ALU_pkg: ALU_ctrl_e, members ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
- One combinational sub-module, mips_alu_decoder: funct -> ALU_ctrl_e, instantiated for S_EXECUTE.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-S_MEMREAD -> state S_RESET immediately, all enables 0.
  - Release rst_n -> S_FETCH one cycle later with en_pc=1, en_instr_reg=1.
- lw (opcode 100011):
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles).
  - addr_mux_sel=1 in MEMREAD; rf_we=1, writedata_mux_sel=1 in MEMWB only.
- R-type sub (funct 100010):
  - alu_ctrl=ALU_SUB in EXECUTE.
  - ALUWB asserts rf_we=1, regdst_mux_sel=1; instr_done exactly once.
- beq:
  - alu_zero=1 in BRANCH -> en_pc=1, alurslt_mux_sel=1.
  - alu_zero=0 -> en_pc=0; both paths 3 cycles.
- ori (001101): ORIEX has srcB_mux_sel=3, alu_ctrl=ALU_OR; IMMWB has regdst_mux_sel=0.
- opcode 111111:
  - With MIPS_CU_ILLEGAL_TRAP_EN: S_TRAP, illegal_instr=1, no further en_pc.
  - Without: next instruction fetched on cycle 3.
